// File: rtl/reloj_ctrl_if.sv
// Front-panel / datapath bundle for the BCD clock controller.
interface reloj_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_hd;
  logic [3:0] cur_hu;
  logic [3:0] cur_md;
  logic [3:0] cur_mu;
  logic       tick;
  logic       load;
  logic [3:0] ld_hd;
  logic [3:0] ld_hu;
  logic [3:0] ld_md;
  logic [3:0] ld_mu;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output btn_mode, btn_inc, cur_hd, cur_hu, cur_md, cur_mu,
    input  tick, load, ld_hd, ld_hu, ld_md, ld_mu, mode, blink
  );

  modport slave (
    input  btn_mode, btn_inc, cur_hd, cur_hu, cur_md, cur_mu,
    output tick, load, ld_hd, ld_hu, ld_md, ld_mu, mode, blink
  );
endinterface

// File: rtl/reloj_ctrl.sv
// Time-base and two-button time-setting controller for the BCD clock datapath.
// Optional setting-inactivity timeout: define RELOJ_CTRL_TIMEOUT_EN.
//
// state  | meaning
// RUN    | normal timekeeping, tick follows the prescaler wrap
// SET_H  | editing hour pair in shadow registers, tick suppressed
// SET_M  | editing minute pair in shadow registers, tick suppressed
// COMMIT | single cycle: load strobe, ld_* carry the shadow value
module reloj_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int TIMEOUT_S = 30
) (
  input  logic         clk,
  input  logic         rst,
  reloj_ctrl_if.slave  bus
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [CW-1:0] cnt;
  logic       w;
  logic [3:0] sh_hd, sh_hu, sh_md, sh_mu;
  logic [3:0] ld_hd_r, ld_hu_r, ld_md_r, ld_mu_r;
  logic [3:0] inc_hd, inc_hu, inc_md, inc_mu;
  logic       capture, inc_h, inc_m, enter_commit, timeout, setting;

  assign setting = (state == SET_H) || (state == SET_M);

`ifdef RELOJ_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_S + 1);
  logic [TW-1:0] tcnt;

  assign timeout = setting && (tcnt == TW'(TIMEOUT_S));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (timeout || capture || (setting && (bus.btn_mode || bus.btn_inc))) begin
      tcnt <= '0;
    end else if (setting && w) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    capture      = 1'b0;
    inc_h        = 1'b0;
    inc_m        = 1'b0;
    enter_commit = 1'b0;
    case (state)
      RUN: begin
        if (bus.btn_mode) begin
          state_nx = SET_H;
          capture  = 1'b1;
        end
      end
      SET_H: begin
        if (timeout)           state_nx = RUN;
        else if (bus.btn_mode) state_nx = SET_M;
        else if (bus.btn_inc)  inc_h    = 1'b1;
      end
      SET_M: begin
        if (timeout) begin
          state_nx = RUN;
        end else if (bus.btn_mode) begin
          state_nx     = COMMIT;
          enter_commit = 1'b1;
        end else if (bus.btn_inc) begin
          inc_m = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // Out-of-range captured hours (e.g. 24+) wrap straight to 00.
  always_comb begin
    inc_hd = sh_hd;
    inc_hu = sh_hu + 4'd1;
    if ((sh_hd >= 4'd3) || ((sh_hd == 4'd2) && (sh_hu >= 4'd3))) begin
      inc_hd = 4'd0;
      inc_hu = 4'd0;
    end else if (sh_hu >= 4'd9) begin
      inc_hd = sh_hd + 4'd1;
      inc_hu = 4'd0;
    end
  end

  always_comb begin
    inc_md = sh_md;
    inc_mu = sh_mu + 4'd1;
    if (sh_mu >= 4'd9) begin
      inc_mu = 4'd0;
      inc_md = (sh_md >= 4'd5) ? 4'd0 : sh_md + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Prescaler restarts with COMMIT so the first RUN tick lands TICK_DIV cycles after load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      w   <= 1'b0;
    end else if (enter_commit || timeout) begin
      cnt <= '0;
      w   <= 1'b0;
    end else begin
      w   <= (cnt == CNT_MAX);
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_hd <= 4'd0;
      sh_hu <= 4'd0;
      sh_md <= 4'd0;
      sh_mu <= 4'd0;
    end else if (timeout) begin
      sh_hd <= 4'd0;
      sh_hu <= 4'd0;
      sh_md <= 4'd0;
      sh_mu <= 4'd0;
    end else if (capture) begin
      sh_hd <= bus.cur_hd;
      sh_hu <= bus.cur_hu;
      sh_md <= bus.cur_md;
      sh_mu <= bus.cur_mu;
    end else if (inc_h) begin
      sh_hd <= inc_hd;
      sh_hu <= inc_hu;
    end else if (inc_m) begin
      sh_md <= inc_md;
      sh_mu <= inc_mu;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_hd_r <= 4'd0;
      ld_hu_r <= 4'd0;
      ld_md_r <= 4'd0;
      ld_mu_r <= 4'd0;
    end else if (enter_commit) begin
      ld_hd_r <= sh_hd;
      ld_hu_r <= sh_hu;
      ld_md_r <= sh_md;
      ld_mu_r <= sh_mu;
    end
  end

  assign bus.mode  = state;
  assign bus.tick  = w && (state == RUN);
  assign bus.load  = (state == COMMIT);
  assign bus.blink = setting && (cnt < CNT_HALF);
  assign bus.ld_hd = ld_hd_r;
  assign bus.ld_hu = ld_hu_r;
  assign bus.ld_md = ld_md_r;
  assign bus.ld_mu = ld_mu_r;

endmodule

// File: tb/tb_reloj_ctrl.sv
// Self-checking bench for reloj_ctrl: vector table with a scoreboard queue, plus setting-persistence/timeout sequences.
module tb_reloj_ctrl;
  localparam int TD = 4;
  localparam int TO = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reloj_ctrl_if bus();

  reloj_ctrl #(.TICK_DIV(TD), .TIMEOUT_S(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r;
    logic        bm;
    logic        bi;
    logic [15:0] cur;
    logic [1:0]  mode;
    logic        load;
    logic [15:0] ld;
  } vec_t;

  typedef struct {
    logic [1:0]  mode;
    logic        tick;
    logic        load;
    logic        blink;
    logic [15:0] ld;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   ph = 0;

  function automatic vec_t v(logic r, logic bm, logic bi, logic [15:0] cur,
                             logic [1:0] m, logic ld_s, logic [15:0] ld);
    vec_t x;
    x.r = r; x.bm = bm; x.bi = bi; x.cur = cur;
    x.mode = m; x.load = ld_s; x.ld = ld;
    return x;
  endfunction

  function automatic logic [15:0] ld_bus();
    return {bus.ld_hd, bus.ld_hu, bus.ld_md, bus.ld_mu};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ph tracks the prescaler phase: 0 right after reset or in the COMMIT cycle.
  task automatic step(input vec_t x);
    exp_t e;
    rst          = x.r;
    bus.btn_mode = x.bm;
    bus.btn_inc  = x.bi;
    {bus.cur_hd, bus.cur_hu, bus.cur_md, bus.cur_mu} = x.cur;
    ph      = (x.r || x.mode == 2'd3) ? 0 : ph + 1;
    e.mode  = x.mode;
    e.load  = x.load;
    e.ld    = x.ld;
    e.tick  = (x.mode == 2'd0) && (ph % TD == 0) && (ph != 0);
    e.blink = (x.mode == 2'd1 || x.mode == 2'd2) && (ph % TD < TD / 2);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("mode",  16'(bus.mode),  16'(e.mode));
    check("tick",  16'(bus.tick),  16'(e.tick));
    check("load",  16'(bus.load),  16'(e.load));
    check("blink", 16'(bus.blink), 16'(e.blink));
    check("ld",    ld_bus(),       e.ld);
    rst          = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
  endtask

  task automatic pulse(input logic bm, input logic bi);
    bus.btn_mode = bm;
    bus.btn_inc  = bi;
    @(posedge clk); #1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    int          bad;
    rst = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    {bus.cur_hd, bus.cur_hu, bus.cur_md, bus.cur_mu} = 16'h0000;

    vecs.push_back(v(1, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vecs.push_back(v(1, 0, 0, 16'h0000, 0, 0, 16'h0000));
    for (int i = 0; i < 20; i++) vecs.push_back(v(0, 0, 0, 16'h1947, 0, 0, 16'h0000));
    // 19:47 -> five hour increments wrap through 23 to 00
    c = 16'h1947;
    vecs.push_back(v(0, 1, 0, c, 1, 0, 16'h0000));
    for (int i = 0; i < 5; i++) vecs.push_back(v(0, 0, 1, c, 1, 0, 16'h0000));
    vecs.push_back(v(0, 1, 0, c, 2, 0, 16'h0000));
    vecs.push_back(v(0, 1, 0, c, 3, 1, 16'h0047));
    vecs.push_back(v(0, 0, 0, c, 0, 0, 16'h0047));
    vecs.push_back(v(0, 0, 1, c, 0, 0, 16'h0047));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0, 0, 0, c, 0, 0, 16'h0047));
    // 16:58 -> minutes 59, 00, no hour carry
    c = 16'h1658;
    vecs.push_back(v(0, 1, 0, c, 1, 0, 16'h0047));
    vecs.push_back(v(0, 1, 0, c, 2, 0, 16'h0047));
    vecs.push_back(v(0, 0, 1, c, 2, 0, 16'h0047));
    vecs.push_back(v(0, 0, 1, c, 2, 0, 16'h0047));
    vecs.push_back(v(0, 1, 0, c, 3, 1, 16'h1600));
    vecs.push_back(v(0, 0, 0, c, 0, 0, 16'h1600));
    vecs.push_back(v(0, 0, 0, c, 0, 0, 16'h1600));
    // simultaneous buttons in SET_H: mode wins, hour untouched
    c = 16'h0830;
    vecs.push_back(v(0, 1, 0, c, 1, 0, 16'h1600));
    vecs.push_back(v(0, 1, 1, c, 2, 0, 16'h1600));
    vecs.push_back(v(0, 1, 0, c, 3, 1, 16'h0830));
    vecs.push_back(v(0, 0, 0, c, 0, 0, 16'h0830));
    // invalid captured hour 25 -> 00 on first increment; minute 30 -> 31
    c = 16'h2530;
    vecs.push_back(v(0, 1, 0, c, 1, 0, 16'h0830));
    vecs.push_back(v(0, 0, 1, c, 1, 0, 16'h0830));
    vecs.push_back(v(0, 1, 0, c, 2, 0, 16'h0830));
    vecs.push_back(v(0, 0, 1, c, 2, 0, 16'h0830));
    vecs.push_back(v(0, 1, 0, c, 3, 1, 16'h0031));
    vecs.push_back(v(0, 0, 0, c, 0, 0, 16'h0031));
    // reset in the middle of SET_M: no load, ld cleared
    c = 16'h1234;
    vecs.push_back(v(0, 1, 0, c, 1, 0, 16'h0031));
    vecs.push_back(v(0, 1, 0, c, 2, 0, 16'h0031));
    vecs.push_back(v(1, 0, 0, c, 0, 0, 16'h0000));
    for (int i = 0; i < 6; i++) vecs.push_back(v(0, 0, 0, c, 0, 0, 16'h0000));

    foreach (vecs[i]) step(vecs[i]);

    pulse(1'b1, 1'b0);
    check("enter_set_h", 16'(bus.mode), 16'd1);
`ifdef RELOJ_CTRL_TIMEOUT_EN
    begin
      int n;
      bit seen_load;
      n = 0;
      seen_load = 1'b0;
      while (bus.mode != 2'd0 && n < 40) begin
        @(posedge clk); #1;
        n++;
        if (bus.load) seen_load = 1'b1;
      end
      check("timeout_mode", 16'(bus.mode), 16'd0);
      check("timeout_noload", 16'(seen_load), 16'd0);
      check("timeout_latency_ok", 16'(n >= 8 && n <= 16), 16'd1);
    end
    pulse(1'b1, 1'b0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      pulse(1'b0, 1'b1);
      if (bus.mode != 2'd1) bad++;
      for (int j = 0; j < 7; j++) begin
        @(posedge clk); #1;
        if (bus.mode != 2'd1) bad++;
      end
    end
    check("no_timeout_with_inc", 16'(bad), 16'd0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("commit_load", 16'(bus.load), 16'd1);
    check("commit_ld", ld_bus(), 16'h1734);
`else
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.mode != 2'd1 || bus.tick || bus.load) bad++;
    end
    check("set_h_persists", 16'(bad), 16'd0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("commit_load", 16'(bus.load), 16'd1);
    check("commit_ld", ld_bus(), 16'h1234);
`endif
    @(posedge clk); #1;
    check("back_to_run", 16'(bus.mode), 16'd0);
    check("load_cleared", 16'(bus.load), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
